// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// master drives operands and observes results; slave is the adder itself.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             out_valid;

    modport master (
        output in_valid, A, B, Cin,
        input  Sum, Cout, out_valid
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output Sum, Cout, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + Cin, one cycle after in_valid.
// Built from per-bit full-adder cells; outputs come only from flops.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    assign carry[0] = bus.Cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic prop;
            assign prop           = bus.A[gi] ^ bus.B[gi];
            assign sum_d[gi]      = prop ^ carry[gi];
            assign carry[gi + 1]  = (bus.A[gi] & bus.B[gi]) | (carry[gi] & prop);
        end
    endgenerate

    // Result flops only load on in_valid, so operands on idle cycles never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_d;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8 with hand-computed expectations.
module tb_full_adder;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        if1.in_valid = v;
        if1.A        = a;
        if1.B        = b;
        if1.Cin      = c;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.in_valid = v;
        if8.A        = a;
        if8.B        = b;
        if8.Cin      = c;
    endtask

    task automatic check1(input string tag, input logic s, input logic co, input logic ov);
        check({tag, ".sum"},  64'(if1.Sum),       64'(s));
        check({tag, ".cout"}, 64'(if1.Cout),      64'(co));
        check({tag, ".ov"},   64'(if1.out_valid), 64'(ov));
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic co, input logic ov);
        check({tag, ".sum"},  64'(if8.Sum),       64'(s));
        check({tag, ".cout"}, 64'(if8.Cout),      64'(co));
        check({tag, ".ov"},   64'(if8.out_valid), 64'(ov));
    endtask

    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    logic [2:0] tt_in;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rexp;

    initial begin
        checks = 0;
        errors = 0;
        // Truth table indexed by {Cin,A,B}
        tt_sum  = 8'b1001_0110;
        tt_cout = 8'b1110_1000;

        // Reset dominates a valid input
        rst_n = 1'b0;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        step();
        step();
        check1("rst1", 1'b0, 1'b0, 1'b0);
        check8("rst8", 8'h00, 1'b0, 1'b0);

        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check1("post_rst", 1'b1, 1'b0, 1'b1);
        check8("idle8", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            tt_in = 3'(i);
            drive1(1'b1, tt_in[1], tt_in[0], tt_in[2]);
            step();
            check1($sformatf("tt%0d", i), tt_sum[i], tt_cout[i], 1'b1);
        end

        // Last captured 1+1+1 -> 1/1; must hold while idle, even with X operands
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check1("hold", 1'b1, 1'b1, 1'b0);
        if1.A   = 1'bx;
        if1.B   = 1'bz;
        if1.Cin = 1'bx;
        step();
        check1("hold_x", 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                drive1(1'b1, 1'b1, 1'b0, 1'b0);
                step();
                check1($sformatf("b2b%0d", i), 1'b1, 1'b0, 1'b1);
            end else begin
                drive1(1'b1, 1'b1, 1'b1, 1'b0);
                step();
                check1($sformatf("b2b%0d", i), 1'b0, 1'b1, 1'b1);
            end
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        drive8(1'b1, 8'hFF, 8'h00, 1'b1);
        step();
        check8("wrap", 8'h00, 1'b1, 1'b1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        step();
        check8("max", 8'hFF, 1'b1, 1'b1);
        drive8(1'b1, 8'h5A, 8'hA5, 1'b0);
        step();
        check8("alt", 8'hFF, 1'b0, 1'b1);
        drive8(1'b1, 8'h80, 8'h80, 1'b0);
        step();
        check8("msb", 8'h00, 1'b1, 1'b1);
        drive8(1'b1, 8'h10, 8'hFE, 1'b1);
        step();
        check8("sub", 8'h0F, 1'b1, 1'b1);
        drive8(1'b1, 8'h00, 8'h00, 1'b0);
        step();
        check8("zero", 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            drive8(1'b1, ra, rb, rc);
            step();
            check8($sformatf("rnd%0d", i), rexp[7:0], rexp[8], 1'b1);
        end
        drive8(1'b0, 8'h00, 8'h00, 1'b0);

        // Mid-stream reset between two valid inputs
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check1("mid_pre", 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check1("mid_rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check1("mid_post", 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
